// File: rtl/trace_pkg.sv
// Shared widths, buffer geometry, record layout and checker state codes
// for the retire-trace checker.
package trace_pkg;

  localparam int PC_W       = 32;
  localparam int WNUM_W     = 5;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int REC_W      = PC_W + WNUM_W + DATA_W;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WNUM_W-1:0] wnum;
    logic [DATA_W-1:0] wdata;
  } trace_rec_t;

  function automatic logic rec_equal(input trace_rec_t a, input trace_rec_t b);
    return (a.pc == b.pc) && (a.wnum == b.wnum) && (a.wdata == b.wdata);
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock FIFO with a combinational head so the consumer can compare
// and pop in the same cycle; push+pop is accepted even when full.
module trace_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/trace_checker.sv
// Buffers retired register writes from the CPU trace and compares them in
// order against a golden trace stream, reporting RUN/PASS/FAIL.
module trace_checker
  import trace_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   debug_wb_pc,
  input  logic [3:0]        debug_wb_rf_wen,
  input  logic [WNUM_W-1:0] debug_wb_rf_wnum,
  input  logic [DATA_W-1:0] debug_wb_rf_wdata,
  input  logic              gold_valid,
  output logic              gold_ready,
  input  logic [PC_W-1:0]   gold_pc,
  input  logic [WNUM_W-1:0] gold_wnum,
  input  logic [DATA_W-1:0] gold_wdata,
  input  logic              check_en,
  input  logic [PC_W-1:0]   end_pc,
  output logic [1:0]        state,
  output logic [31:0]       match_cnt,
  output logic [PC_W-1:0]   err_pc,
  output logic [DATA_W-1:0] err_wdata,
  output logic [DATA_W-1:0] exp_wdata,
  output logic              overflow
);

  logic [1:0]        state_q, state_d;
  logic [31:0]       match_cnt_q, match_cnt_d;
  logic [PC_W-1:0]   err_pc_q, err_pc_d;
  logic [DATA_W-1:0] err_wdata_q, err_wdata_d;
  logic [DATA_W-1:0] exp_wdata_q, exp_wdata_d;
  logic              overflow_q, overflow_d;

  trace_rec_t        incoming, head, gold;
  logic [REC_W-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_flush;
  logic [CNT_W-1:0]  unused_fifo_count;
  logic              active, retire, push, pop;
  logic              hit, mismatch, ovf;

  assign incoming = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};
  assign gold     = '{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata};
  assign head     = trace_rec_t'(fifo_rdata);

  // Only RUN with the enable still high moves records; everything else drops them.
  assign active     = (state_q == ST_RUN) && check_en;
  assign retire     = (|debug_wb_rf_wen) && (debug_wb_rf_wnum != '0);
  assign push       = active && retire;
  assign pop        = active && !fifo_empty && gold_valid;
  assign gold_ready = pop;
  assign fifo_flush = (state_q == ST_IDLE) || !check_en;

  assign hit      = pop && rec_equal(head, gold);
  assign mismatch = pop && !rec_equal(head, gold);
  assign ovf      = push && fifo_full && !pop;

  trace_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (push),
    .wdata (incoming),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_pc_d    = err_pc_q;
    err_wdata_d = err_wdata_q;
    exp_wdata_d = exp_wdata_q;
    overflow_d  = overflow_q;
    if (!check_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_RUN;
          match_cnt_d = '0;
          err_pc_d    = '0;
          err_wdata_d = '0;
          exp_wdata_d = '0;
          overflow_d  = 1'b0;
        end
        ST_RUN: begin
          if (mismatch) begin
            // A compared head takes precedence for the error capture.
            state_d     = ST_FAIL;
            overflow_d  = ovf;
            err_pc_d    = head.pc;
            err_wdata_d = head.wdata;
            exp_wdata_d = gold_wdata;
          end else if (ovf) begin
            state_d     = ST_FAIL;
            overflow_d  = 1'b1;
            err_pc_d    = incoming.pc;
            err_wdata_d = incoming.wdata;
            exp_wdata_d = '0;
          end else if (hit) begin
            match_cnt_d = match_cnt_q + 32'd1;
            if (head.pc == end_pc) begin
              state_d = ST_PASS;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      err_pc_q    <= '0;
      err_wdata_q <= '0;
      exp_wdata_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      err_pc_q    <= err_pc_d;
      err_wdata_q <= err_wdata_d;
      exp_wdata_q <= exp_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

  assign state     = state_q;
  assign match_cnt = match_cnt_q;
  assign err_pc    = err_pc_q;
  assign err_wdata = err_wdata_q;
  assign exp_wdata = exp_wdata_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker: directed scenarios plus a random soak,
// all checked against a queue-based model of the checker's rules.
module tb_trace_checker;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;
  localparam logic [31:0] END_PC = 32'hBFC0_0100;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic        check_en;
  logic [31:0] end_pc;
  logic [1:0]  state;
  logic [31:0] match_cnt;
  logic [31:0] err_pc;
  logic [31:0] err_wdata;
  logic [31:0] exp_wdata;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_state = M_IDLE;
  rec_t        m_q[$];
  logic [31:0] m_cnt = 0, m_errpc = 0, m_errwd = 0, m_expwd = 0;
  logic        m_ovf = 1'b0;

  // Golden-trace source
  rec_t        gold_q[$];
  logic        want_gv = 1'b0;
  logic [31:0] gold_xor = 32'h0;

  trace_checker dut (
    .clk               (clk),
    .reset             (reset),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .gold_valid        (gold_valid),
    .gold_ready        (gold_ready),
    .gold_pc           (gold_pc),
    .gold_wnum         (gold_wnum),
    .gold_wdata        (gold_wdata),
    .check_en          (check_en),
    .end_pc            (end_pc),
    .state             (state),
    .match_cnt         (match_cnt),
    .err_pc            (err_pc),
    .err_wdata         (err_wdata),
    .exp_wdata         (exp_wdata),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the behavioural model, applied to the inputs currently driven.
  task automatic model_step(output bit popped, output bit pushed);
    rec_t inc, head;
    bit   retire, over, good;
    popped = 0;
    pushed = 0;
    good   = 0;
    head   = '{pc: 0, wnum: 0, wdata: 0};
    if (reset) begin
      m_state = M_IDLE; m_q.delete();
      m_cnt = 0; m_errpc = 0; m_errwd = 0; m_expwd = 0; m_ovf = 0;
      return;
    end
    if (!check_en) begin
      m_state = M_IDLE; m_q.delete();
      return;
    end
    case (m_state)
      M_IDLE: begin
        m_state = M_RUN;
        m_cnt = 0; m_errpc = 0; m_errwd = 0; m_expwd = 0; m_ovf = 0;
      end
      M_RUN: begin
        retire = (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0);
        inc    = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};
        popped = (m_q.size() > 0) && gold_valid;
        over   = retire && !popped && (m_q.size() == 8);
        if (popped) begin
          head = m_q.pop_front();
          good = (head.pc == gold_pc) && (head.wnum == gold_wnum) && (head.wdata == gold_wdata);
        end
        if (retire && !over) begin
          m_q.push_back(inc);
          pushed = 1;
        end
        if (popped && !good) begin
          m_state = M_FAIL; m_errpc = head.pc; m_errwd = head.wdata; m_expwd = gold_wdata; m_ovf = over;
        end else if (over) begin
          m_state = M_FAIL; m_ovf = 1; m_errpc = inc.pc; m_errwd = inc.wdata; m_expwd = 0;
        end else if (popped) begin
          m_cnt = m_cnt + 1;
          if (head.pc == end_pc) m_state = M_PASS;
        end
      end
      default: begin
      end
    endcase
  endtask

  // Drive gold side, check gold_ready, advance one clock, check registered outputs.
  task automatic tick();
    bit   popped, pushed, exp_ready;
    rec_t r;
    gold_valid = want_gv;
    if (gold_q.size() > 0) begin
      gold_pc = gold_q[0].pc; gold_wnum = gold_q[0].wnum; gold_wdata = gold_q[0].wdata;
    end else begin
      gold_pc = $urandom; gold_wnum = 5'($urandom); gold_wdata = $urandom;
    end
    #1;
    exp_ready = (m_state == M_RUN) && check_en && (m_q.size() > 0) && gold_valid;
    if (!reset) check("gold_ready", {31'b0, gold_ready}, {31'b0, exp_ready});
    model_step(popped, pushed);
    if (popped) void'(gold_q.pop_front());
    if (pushed) begin
      r = '{pc: debug_wb_pc, wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata ^ gold_xor};
      gold_q.push_back(r);
      gold_xor = 0;
    end
    if (reset || !check_en) gold_q.delete();
    @(posedge clk);
    #1;
    check("state",     {30'b0, state}, 32'(m_state));
    check("match_cnt", match_cnt, m_cnt);
    check("err_pc",    err_pc, m_errpc);
    check("err_wdata", err_wdata, m_errwd);
    check("exp_wdata", exp_wdata, m_expwd);
    check("overflow",  {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  function automatic logic [31:0] rpc();
    return 32'h8000_0000 | ($urandom & 32'h0fff_fffc);
  endfunction

  task automatic ev(input logic [31:0] pc, input logic [31:0] wd);
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = 4'($urandom_range(15, 1));
    debug_wb_rf_wnum  = 5'($urandom_range(31, 1));
    debug_wb_rf_wdata = wd;
    tick();
  endtask

  task automatic noev();
    debug_wb_pc       = $urandom;
    debug_wb_rf_wdata = $urandom;
    if ($urandom_range(1, 0) == 1) begin
      debug_wb_rf_wen  = 4'h0;
      debug_wb_rf_wnum = 5'($urandom);
    end else begin
      debug_wb_rf_wen  = 4'($urandom_range(15, 1));
      debug_wb_rf_wnum = 5'h0;
    end
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && gold_q.size() > 0 && m_state == M_RUN; k++) noev();
  endtask

  task automatic restart();
    check_en = 1'b0;
    noev();
    check("restart_idle", {30'b0, state}, 32'd0);
    check_en = 1'b1;
    noev();
  endtask

  logic [31:0] pc_keep;

  initial begin
    reset = 1'b1; check_en = 1'b0; end_pc = END_PC;
    debug_wb_pc = 0; debug_wb_rf_wen = 0; debug_wb_rf_wnum = 0; debug_wb_rf_wdata = 0;
    gold_valid = 0; gold_pc = 0; gold_wnum = 0; gold_wdata = 0;
    noev();
    noev();
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_ready", {31'b0, gold_ready}, 32'd0);
    check("rst_cnt", match_cnt, 32'd0);
    reset = 1'b0;

    // Ten matching records with interleaved non-writes, last at end_pc.
    check_en = 1'b1; want_gv = 1'b1;
    noev();
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(1, 0) == 1) noev();
      ev((i == 9) ? END_PC : rpc(), $urandom);
    end
    drain();
    check("pass_state", {30'b0, state}, 32'd2);
    check("pass_cnt", match_cnt, 32'd10);

    // Third record corrupted against the golden copy.
    restart();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        pc_keep = rpc();
        gold_xor = 32'h1;
        ev(pc_keep, 32'h1234);
      end else begin
        ev(rpc(), $urandom);
      end
    end
    drain();
    for (int i = 0; i < 3; i++) ev(rpc(), $urandom);
    check("mis_state", {30'b0, state}, 32'd3);
    check("mis_cnt", match_cnt, 32'd2);
    check("mis_err_pc", err_pc, pc_keep);
    check("mis_err_wd", err_wdata, 32'h1234);
    check("mis_exp_wd", exp_wdata, 32'h1235);
    check("mis_ovf", {31'b0, overflow}, 32'd0);

    // Nine back-to-back events with the golden side stalled.
    restart();
    want_gv = 1'b0;
    for (int i = 0; i < 8; i++) ev(rpc(), $urandom);
    check("ovf8_state", {30'b0, state}, 32'd1);
    pc_keep = rpc();
    ev(pc_keep, 32'hDEAD_0009);
    check("ovf_state", {30'b0, state}, 32'd3);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    check("ovf_err_pc", err_pc, pc_keep);
    check("ovf_err_wd", err_wdata, 32'hDEAD_0009);
    check("ovf_exp_wd", exp_wdata, 32'd0);

    // Full buffer, golden side resumes on the ninth event: no overflow.
    restart();
    want_gv = 1'b0;
    for (int i = 0; i < 8; i++) ev(rpc(), $urandom);
    want_gv = 1'b1;
    ev(END_PC, $urandom);
    drain();
    check("full_ovf", {31'b0, overflow}, 32'd0);
    check("full_cnt", match_cnt, 32'd9);
    check("full_state", {30'b0, state}, 32'd2);

    // Reset with five records buffered.
    restart();
    want_gv = 1'b1;
    ev(rpc(), $urandom);
    noev();
    want_gv = 1'b0;
    for (int i = 0; i < 5; i++) ev(rpc(), $urandom);
    check("prerst_cnt", match_cnt, 32'd1);
    reset = 1'b1;
    want_gv = 1'b1;
    noev();
    reset = 1'b0;
    check("midrst_state", {30'b0, state}, 32'd0);
    check("midrst_ready", {31'b0, gold_ready}, 32'd0);
    check("midrst_cnt", match_cnt, 32'd0);
    noev();
    noev();

    // Random soak against the model.
    for (int c = 0; c < 600; c++) begin
      if (m_state == M_PASS || m_state == M_FAIL) check_en = 1'b0;
      else if ($urandom_range(59, 0) == 0) check_en = 1'b0;
      else check_en = 1'b1;
      want_gv = ($urandom_range(2, 0) != 0);
      if ($urandom_range(79, 0) == 0) gold_xor = 32'h1 << $urandom_range(31, 0);
      if ($urandom_range(1, 0) == 1) ev(($urandom_range(39, 0) == 0) ? END_PC : rpc(), $urandom);
      else noev();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have: clk  in  1  clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: debug_wb_pc  in  32  retired-instruction PC from trace FIFO.
REQ-004 SHALL have: debug_wb_rf_wen  in  4  byte write enables; any nonzero = write.
REQ-005 SHALL have: debug_wb_rf_wnum  in  5  destination register number.
REQ-006 SHALL have: debug_wb_rf_wdata  in  32  destination register data.
REQ-007 SHALL have: gold_valid  in  1; gold_ready  out  1  golden-trace handshake.
REQ-008 SHALL have: gold_pc  in  32; gold_wnum  in  5; gold_wdata  in  32  expected record.
REQ-009 SHALL have: check_en  in  1  enable; low forces IDLE.
REQ-010 SHALL have: end_pc  in  32  PC marking test completion.
REQ-011 SHALL have: state  out  2  IDLE=0, RUN=1, PASS=2, FAIL=3.
REQ-012 SHALL have: match_cnt  out  32  count of matched records.
REQ-013 SHALL have: err_pc, err_wdata, exp_wdata  out  32 each  capture of first failing record.
REQ-014 SHALL have: overflow  out  1  set when FAIL caused by buffer overflow.

Function
REQ-015 Retire event SHALL be |debug_wb_rf_wen && debug_wb_rf_wnum != 0; all other cycles ignored.
REQ-016 Trace input has no backpressure; every retire event in RUN SHALL be pushed into an 8-entry, 69-bit buffer {pc, wnum, wdata}.
REQ-017 Compare SHALL occur only from buffer head: in RUN, buffer non-empty and gold_valid=1 -> gold_ready=1, head popped, fields compared same cycle.
REQ-018 gold_ready SHALL be 0 outside RUN or when buffer empty.
REQ-019 Minimum latency event-in to state update SHALL be 2 cycles (push cycle, compare cycle; state/outputs registered at compare edge).
REQ-020 Equal pc, wnum, wdata -> match_cnt += 1 (wraps modulo 2^32).
REQ-021 Any field unequal -> state FAIL; err_pc/err_wdata <= head pc/wdata, exp_wdata <= gold_wdata.
REQ-022 Matched record with pc == end_pc -> state PASS.
REQ-023 Push to full buffer without simultaneous pop -> FAIL, overflow=1, err_* <= incoming record, exp_wdata <= 0.
REQ-024 Push and pop in same cycle SHALL be legal at any occupancy, including full (count unchanged).
REQ-025 Buffer pointers SHALL wrap modulo 8; count range 0..8.
REQ-026 FSM: IDLE->RUN when check_en=1; RUN->PASS/FAIL per REQ-021..023; PASS/FAIL hold until check_en=0; any state ->IDLE when check_en=0.
REQ-027 Mismatch and overflow in same cycle -> FAIL with overflow=1, err_* from compared head.
REQ-028 PASS/FAIL SHALL freeze match_cnt, err_*, overflow; no pushes/pops.
REQ-029 IDLE SHALL flush buffer; IDLE->RUN SHALL clear match_cnt, err_*, overflow.
REQ-030 Events arriving while in IDLE (including the IDLE->RUN cycle) SHALL be discarded.

Reset
REQ-031 reset SHALL set state=IDLE, buffer empty, gold_ready=0, match_cnt=0, err_pc=err_wdata=exp_wdata=0, overflow=0.
REQ-032 reset mid-RUN SHALL discard buffered records with no output pulse; buffer RAM contents need not be cleared.

Structure
REQ-033 Package trace_pkg SHALL hold widths (PC 32, WNUM 5, DATA 32), depth 8, record width 69, state encodings.
REQ-034 Buffer SHALL be sub-module trace_sync_fifo (parameterised depth/width, push/pop/full/empty/count, flush input).

Verification
REQ-035 10 matching records, gold_valid always 1, last pc=end_pc=0xBFC0_0100 -> PASS, match_cnt=10.
REQ-036 Record 3 wdata 0x1234 vs gold 0x1235 -> FAIL after 2 matches, err_wdata=0x1234, exp_wdata=0x1235.
REQ-037 gold_valid=0 while 9 retire events arrive back-to-back -> FAIL, overflow=1 on 9th push.
REQ-038 Events with wnum=0 or wen=0 interleaved -> ignored; match_cnt counts only valid writes.
REQ-039 8 buffered, gold_valid raised same cycle as 9th event -> no overflow, all 9 matched.
REQ-040 reset asserted with 5 records buffered -> next cycle state=IDLE, gold_ready=0, match_cnt=0.
